// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low glyphs {g,f,e,d,c,b,a} for 0-F,
// the all-off pattern, and the two-state scan FSM encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment glyph.
// Zero latency; no flow control.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg_n
);

    always_comb begin
        o_seg_n = SEG_BLANK;
        case (i_digit)
            4'h0: o_seg_n = SEG_0;
            4'h1: o_seg_n = SEG_1;
            4'h2: o_seg_n = SEG_2;
            4'h3: o_seg_n = SEG_3;
            4'h4: o_seg_n = SEG_4;
            4'h5: o_seg_n = SEG_5;
            4'h6: o_seg_n = SEG_6;
            4'h7: o_seg_n = SEG_7;
            4'h8: o_seg_n = SEG_8;
            4'h9: o_seg_n = SEG_9;
            4'hA: o_seg_n = SEG_A;
            4'hB: o_seg_n = SEG_B;
            4'hC: o_seg_n = SEG_C;
            4'hD: o_seg_n = SEG_D;
            4'hE: o_seg_n = SEG_E;
            4'hF: o_seg_n = SEG_F;
            default: o_seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/counter_display_scan.sv
// Synchronises/debounces an async 4-bit count, counts 15->0 wraps, and scans a
// 4-digit common-anode display. Count latency SYNC_STAGES+STABLE_CYCLES; no backpressure.
module counter_display_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_CYCLES = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int STABLE_CYCLES  = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] count_async,
    output logic [3:0] count_sync,
    output logic [3:0] wrap_count,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n
);

    localparam int TMAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int TW   = ($clog2(TMAX) > 0) ? $clog2(TMAX) : 1;
    localparam int RW   = $clog2(STABLE_CYCLES + 1);

    localparam logic [TW-1:0] T_SHOW_LAST  = TW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] T_BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [RW-1:0] RUN_MAX      = RW'(STABLE_CYCLES);

    logic [3:0]    r_sync [SYNC_STAGES];
    logic [3:0]    r_cand;
    logic [RW-1:0] r_run;
    scan_state_t   r_state;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_digit;

    logic [3:0]    w_s;
    logic [3:0]    w_cand_nxt;
    logic [RW-1:0] w_run_nxt;
    logic          w_accept;
    logic          w_wrap_evt;
    scan_state_t   w_state_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic [1:0]    w_digit_nxt;
    logic          w_tens;
    logic [3:0]    w_ones;
    logic [3:0]    w_dig_val;
    logic          w_dig_blank;
    logic [6:0]    w_glyph;

    // reset_n is released synchronously to clock by the board reset logic.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= count_async;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Acceptance looks at the post-edge run length so a value is taken on the
    // same edge its run reaches STABLE_CYCLES.
    always_comb begin
        w_cand_nxt = r_cand;
        w_run_nxt  = r_run;
        if (w_s != r_cand) begin
            w_cand_nxt = w_s;
            w_run_nxt  = RW'(1);
        end else if (r_run != RUN_MAX) begin
            w_run_nxt = r_run + RW'(1);
        end
    end

    assign w_accept   = (w_run_nxt == RUN_MAX) && (w_cand_nxt != count_sync);
    assign w_wrap_evt = w_accept && (count_sync == 4'hF) && (w_cand_nxt == 4'h0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cand     <= '0;
            r_run      <= '0;
            count_sync <= '0;
            wrap_count <= '0;
        end else begin
            r_cand <= w_cand_nxt;
            r_run  <= w_run_nxt;
            if (w_accept) count_sync <= w_cand_nxt;
            if (w_wrap_evt) wrap_count <= (wrap_count == 4'd9) ? 4'd0 : wrap_count + 4'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + TW'(1);
        w_digit_nxt = r_digit;
        case (r_state)
            BLANK: begin
                if (r_timer == T_BLANK_LAST) begin
                    w_state_nxt = SHOW;
                    w_timer_nxt = '0;
                end
            end
            SHOW: begin
                if (r_timer == T_SHOW_LAST) begin
                    w_state_nxt = BLANK;
                    w_timer_nxt = '0;
                    w_digit_nxt = r_digit + 2'd1;
                end
            end
            default: w_state_nxt = BLANK;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BLANK;
            r_timer <= '0;
            r_digit <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_digit <= w_digit_nxt;
        end
    end

    assign w_tens = (count_sync >= 4'd10);
    assign w_ones = w_tens ? (count_sync - 4'd10) : count_sync;

    always_comb begin
        w_dig_val   = '0;
        w_dig_blank = 1'b0;
        case (w_digit_nxt)
            2'd0: w_dig_val = w_ones;
            2'd1: begin
                w_dig_val   = {3'b000, w_tens};
                w_dig_blank = !w_tens;
            end
            2'd2: w_dig_val = count_sync;
            2'd3: w_dig_val = wrap_count;
            default: w_dig_val = '0;
        endcase
    end

    seg7_decode u_decode (
        .i_digit (w_dig_val),
        .o_seg_n (w_glyph)
    );

    // Outputs follow the next state so the display lines up with the FSM state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            an_n  <= 4'hF;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else if (w_state_nxt == SHOW) begin
            an_n  <= ~(4'b0001 << w_digit_nxt);
            seg_n <= w_dig_blank ? SEG_BLANK : w_glyph;
            dp_n  <= (w_digit_nxt != 2'd2);
        end else begin
            an_n  <= 4'hF;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end
    end

endmodule
